// File: rtl/restoring_divider_8bit.sv
// restoring_divider_8bit
//   Sequential unsigned restoring divider. It resolves one quotient bit per
//   clock through a trial subtraction, so a full result takes WIDTH
//   iterations. A start/done handshake lets one divider be shared between
//   several requesters.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request a division (sampled on clk rising edge)
//   dividend     unsigned dividend, sampled with start
//   divisor      unsigned divisor, sampled with start
//   busy         high while an iteration sequence is running
//   done         one-cycle pulse when quotient/remainder/div_by_zero update
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  registered flag for the last completed operation
module restoring_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;

  logic [WIDTH:0]   s_next;
  logic [WIDTH:0]   t_next;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             qbit;
  logic             accept;

  // S - {0,D} as S + ~{0,D} + 1; bit WIDTH set means the trial went negative.
  function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0]   s,
                                               input logic [WIDTH-1:0] d);
    return s + {1'b1, ~d} + {{WIDTH{1'b0}}, 1'b1};
  endfunction

  assign accept = (state == IDLE) && start && (divisor != '0);

  // One restoring iteration: shift in next dividend bit, try to subtract.
  always_comb begin
    s_next = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    t_next = trial_sub(s_next, d_reg);
    qbit   = ~t_next[WIDTH];
    r_next = qbit ? t_next : s_next;
    q_next = {q_reg[WIDTH-2:0], qbit};
  end

  // Working registers: only meaningful while in CALC, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_reg <= dividend;
      d_reg <= divisor;
      r_reg <= '0;
    end else if (state == CALC) begin
      q_reg <= q_next;
      r_reg <= r_next;
    end
  end

  // Control FSM and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              state <= CALC;
              cnt   <= CNT_LAST;
              busy  <= 1'b1;
            end else begin
              // Divide by zero completes immediately with a saturated quotient.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end
          end
        end
        CALC: begin
          if (cnt == '0) begin
            quotient    <= q_next;
            remainder   <= r_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
